// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Bundles the IF-stage prediction port, the EX-stage
//                resolution port and the statistics outputs of the branch
//                predictor.
//                slave  - the predictor (consumes IF_PC / IE_*, drives
//                         predictions, redirect and counters)
//                master - the pipeline side (drives IF_PC / IE_*)
//  Signals     : IF_PC, IF_PredTaken, IF_PredTarget,
//                IE_Branch, IE_Stall, IE_PC, IE_Taken, IE_Target,
//                IE_PredTaken, IE_PredTarget,
//                Mispredict, RedirectPC, BranchCount, MissCount
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
   // Fetch-stage prediction
   logic [31:0] IF_PC;
   logic        IF_PredTaken;
   logic [31:0] IF_PredTarget;

   // Execute-stage resolution
   logic        IE_Branch;
   logic        IE_Stall;
   logic [31:0] IE_PC;
   logic        IE_Taken;
   logic [31:0] IE_Target;
   logic        IE_PredTaken;
   logic [31:0] IE_PredTarget;

   // Redirect and statistics
   logic        Mispredict;
   logic [31:0] RedirectPC;
   logic [31:0] BranchCount;
   logic [31:0] MissCount;

   modport master (
      output IF_PC,
      input  IF_PredTaken,
      input  IF_PredTarget,
      output IE_Branch,
      output IE_Stall,
      output IE_PC,
      output IE_Taken,
      output IE_Target,
      output IE_PredTaken,
      output IE_PredTarget,
      input  Mispredict,
      input  RedirectPC,
      input  BranchCount,
      input  MissCount
   );

   modport slave (
      input  IF_PC,
      output IF_PredTaken,
      output IF_PredTarget,
      input  IE_Branch,
      input  IE_Stall,
      input  IE_PC,
      input  IE_Taken,
      input  IE_Target,
      input  IE_PredTaken,
      input  IE_PredTarget,
      output Mispredict,
      output RedirectPC,
      output BranchCount,
      output MissCount
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Dynamic branch predictor for a 5-stage MIPS pipeline.
//                Direct-mapped BTB with a 2-bit saturating counter per entry
//                predicts taken/target for the fetch PC; the resolved EX-stage
//                outcome raises a mispredict/redirect and trains the tables.
//                Saturating counters track resolved branches and mispredicts.
//  Ports       : clk   - clock, all state changes on the rising edge
//                rst_n - synchronous reset, active low
//                bp    - branch_predictor_if.slave (prediction, resolution,
//                        redirect and statistics signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_predictor_if.slave  bp
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   localparam logic [1:0]  CTR_RESET = 2'b01;   // weakly not-taken
   localparam logic [1:0]  CTR_ALLOC = 2'b10;   // weakly taken
   localparam logic [1:0]  CTR_MAX   = 2'b11;
   localparam logic [1:0]  CTR_MIN   = 2'b00;
   localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

   // ------------------------------------------------------------------------
   // Table storage. valid and counter need reset; tag and target are only
   // meaningful behind a set valid bit, so they carry no reset.
   // ------------------------------------------------------------------------
   logic                valid_q  [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];

   logic [31:0]         branch_cnt_q, branch_cnt_d;
   logic [31:0]         miss_cnt_q,   miss_cnt_d;

   // ------------------------------------------------------------------------
   // IF-stage prediction
   // ------------------------------------------------------------------------
   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0]   if_tag;
   logic                  if_hit;
   logic                  if_pred_taken;
   logic [31:0]           if_pc_plus4;

   assign if_idx      = bp.IF_PC[INDEX_BITS+1:2];
   assign if_tag      = bp.IF_PC[31:INDEX_BITS+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign if_pc_plus4 = bp.IF_PC + 32'd4;

   // While reset is held the table is treated as already cleared, so the
   // first reset cycle does not leak stale predictions.
   assign if_pred_taken    = rst_n && if_hit && ctr_q[if_idx][1];
   assign bp.IF_PredTaken  = if_pred_taken;
   assign bp.IF_PredTarget = if_pred_taken ? target_q[if_idx] : if_pc_plus4;

   // ------------------------------------------------------------------------
   // EX-stage resolution
   // ------------------------------------------------------------------------
   logic [INDEX_BITS-1:0] ie_idx;
   logic [TAG_BITS-1:0]   ie_tag;
   logic                  ie_hit;
   logic                  upd_en;
   logic                  mispredict;
   logic [31:0]           ie_pc_plus4;

   assign ie_idx      = bp.IE_PC[INDEX_BITS+1:2];
   assign ie_tag      = bp.IE_PC[31:INDEX_BITS+2];
   assign ie_hit      = valid_q[ie_idx] && (tag_q[ie_idx] == ie_tag);
   assign ie_pc_plus4 = bp.IE_PC + 32'd4;

   // A stalled branch is still in EX next cycle; it is resolved exactly once,
   // on the cycle the stall releases.
   assign upd_en = bp.IE_Branch && !bp.IE_Stall;

   // A correctly predicted not-taken branch is right regardless of the
   // carried target, so the target only matters when actually taken.
   assign mispredict = upd_en &&
                       ((bp.IE_PredTaken != bp.IE_Taken) ||
                        (bp.IE_Taken && (bp.IE_PredTarget != bp.IE_Target)));

   assign bp.Mispredict = mispredict;
   assign bp.RedirectPC = bp.IE_Taken ? bp.IE_Target : ie_pc_plus4;

   // ------------------------------------------------------------------------
   // Table update decode
   //   hit            : train counter, refresh target when taken
   //   miss and taken : allocate / evict with a weakly-taken counter
   //   miss, not taken: leave the table alone so aliases survive
   // ------------------------------------------------------------------------
   logic [1:0] ctr_cur;
   logic [1:0] ctr_d;
   logic       tbl_wr;      // valid + counter write
   logic       tt_wr;       // tag + target write

   assign ctr_cur = ctr_q[ie_idx];
   assign tbl_wr  = upd_en && (ie_hit || bp.IE_Taken);
   assign tt_wr   = upd_en && bp.IE_Taken;

   always_comb begin
      ctr_d = CTR_ALLOC;
      if (ie_hit) begin
         if (bp.IE_Taken) begin
            ctr_d = (ctr_cur == CTR_MAX) ? CTR_MAX : ctr_cur + 2'd1;
         end else begin
            ctr_d = (ctr_cur == CTR_MIN) ? CTR_MIN : ctr_cur - 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Statistics, saturating
   // ------------------------------------------------------------------------
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (upd_en && (branch_cnt_q != CNT_MAX)) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (mispredict && (miss_cnt_q != CNT_MAX)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   assign bp.BranchCount = branch_cnt_q;
   assign bp.MissCount   = miss_cnt_q;

   // ------------------------------------------------------------------------
   // State registers. Reset has priority over a same-cycle update.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_RESET;
         end
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (tbl_wr) begin
            valid_q[ie_idx] <= 1'b1;
            ctr_q[ie_idx]   <= ctr_d;
         end
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && tt_wr) begin
         tag_q[ie_idx]    <= ie_tag;
         target_q[ie_idx] <= bp.IE_Target;
      end
   end

   // Byte-offset bits of both PCs play no part in indexing or tagging.
   logic w_unused_pc_bits;
   assign w_unused_pc_bits = ^{bp.IF_PC[1:0], bp.IE_PC[1:0]};

endmodule
`default_nettype wire
